// File: rtl/spi_3wire_slave.sv
// Mode-0 3-wire SPI slave with a shared SDIO line, bridging frames to one-clk register strobes.
// All pins are resynchronised into clk; the FSM acts only on synchronised edges.
module spi_3wire_slave #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              sdio_in,
  output logic              sdio_out,
  output logic              sdio_oe,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RLOAD, RDATA, DONE} state_t;

  localparam int SH_W  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1);

  state_t            state_q, state_d;
  logic [1:0]        sclk_sync_q, cs_sync_q, sdio_sync_q, vld_q;
  logic              sclk_prev_q, cs_prev_q, armed_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic              sdio_out_q, sdio_out_d, sdio_oe_q, sdio_oe_d, busy_q, busy_d;
  logic              sclk_s, cs_s, sdio_s;
  logic              sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
  logic [ADDR_W:0]   cmd_s;
  logic [DATA_W-1:0] data_s;

  assign sclk_s      = sclk_sync_q[1];
  assign cs_s        = cs_sync_q[1];
  assign sdio_s      = sdio_sync_q[1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign cs_rise_s   = cs_s & ~cs_prev_q;
  assign cs_fall_s   = ~cs_s & cs_prev_q;
  assign cmd_s       = {shift_q[ADDR_W-1:0], sdio_s};
  assign data_s      = {shift_q[DATA_W-2:0], sdio_s};

  // A cs_n fall only starts a frame once cs_n has been seen high with the
  // synchroniser filled, so a cs_n held low across reset cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      sdio_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      vld_q       <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      sdio_sync_q <= {sdio_sync_q[0], sdio_in};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      vld_q       <= {vld_q[0], 1'b1};
      armed_q     <= armed_q | (vld_q[1] & cs_s);
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      shift_q    <= {SH_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      sdio_out_q <= 1'b0;
      sdio_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      sdio_out_q <= sdio_out_d;
      sdio_oe_q  <= sdio_oe_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; a cs_n rise overrides everything and drops the frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    sdio_out_d = sdio_out_q;
    sdio_oe_d  = sdio_oe_q;
    if (cs_rise_s) begin
      state_d    = IDLE;
      cnt_d      = {CNT_W{1'b0}};
      shift_d    = {SH_W{1'b0}};
      sdio_oe_d  = 1'b0;
      sdio_out_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sdio_oe_d = 1'b0;
          if (cs_fall_s && armed_q) begin
            state_d = CMD;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          sdio_oe_d = 1'b0;
          if (sclk_rise_s) begin
            shift_d = {shift_q[SH_W-2:0], sdio_s};
            if (cnt_q == CNT_W'(ADDR_W)) begin
              addr_d = cmd_s[ADDR_W-1:0];
              cnt_d  = {CNT_W{1'b0}};
              if (cmd_s[ADDR_W]) begin
                state_d = RLOAD;
                rd_en_d = 1'b1;
              end else begin
                state_d = WDATA;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        WDATA: begin
          sdio_oe_d = 1'b0;
          if (sclk_rise_s) begin
            shift_d = {shift_q[SH_W-2:0], sdio_s};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              wdata_d = data_s;
              wr_en_d = 1'b1;
              state_d = DONE;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        RLOAD: begin
          sdio_oe_d = 1'b0;
          shift_d   = SH_W'(rdata);
          cnt_d     = {CNT_W{1'b0}};
          state_d   = RDATA;
        end
        RDATA: begin
          if (sclk_fall_s && (cnt_q != CNT_W'(DATA_W))) begin
            sdio_oe_d  = 1'b1;
            sdio_out_d = shift_q[DATA_W-1];
            shift_d    = {shift_q[SH_W-2:0], 1'b0};
            cnt_d      = cnt_q + CNT_W'(1);
          end else if (sclk_rise_s && (cnt_q == CNT_W'(DATA_W))) begin
            sdio_oe_d = 1'b0;
            cnt_d     = {CNT_W{1'b0}};
            state_d   = DONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        DONE: begin
          sdio_oe_d = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          sdio_oe_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign sdio_out = sdio_out_q;
  assign sdio_oe  = sdio_oe_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;

endmodule

// File: doc/spi_3wire_slave.md
SPI_3WIRE_SLAVE -- requirements
Module: spi_3wire_slave

Interface
REQ-001 Parameter: ADDR_W, default 7, register address width; command frame is 1+ADDR_W bits.
REQ-002 Parameter: DATA_W, default 8, register data width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sclk  input  1  SPI serial clock, mode 0 (idle low), asynchronous to clk.
REQ-006 cs_n  input  1  chip select, active low, asynchronous to clk.
REQ-007 sdio_in  input  1  received level of the shared SDIO line, taken from the pad's receive path.
REQ-008 sdio_out  output  1  bit to drive onto SDIO.
REQ-009 sdio_oe  output  1  pad direction; 1 = drive SDIO, 0 = release SDIO and receive.
REQ-010 wr_en  output  1  one-clk write strobe.
REQ-011 rd_en  output  1  one-clk read request.
REQ-012 addr  output  ADDR_W  register address; valid while wr_en or rd_en is high.
REQ-013 wdata  output  DATA_W  write data; valid while wr_en is high.
REQ-014 rdata  input  DATA_W  read data; sampled exactly one clk after rd_en.
REQ-015 busy  output  1  high from command start until the frame ends or aborts.

Function
REQ-016 sclk, cs_n and sdio_in SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized signals; clk SHALL be at least 8x sclk.
REQ-017 Frame format: command is sent MSB first, bit[ADDR_W] = R/W (1 = read), then bits[ADDR_W-1:0] = address; data follows MSB first, DATA_W bits.
REQ-018 The block SHALL sample sdio_in on each synchronized sclk rising edge and SHALL update sdio_out on each synchronized sclk falling edge.
REQ-019 States: IDLE, CMD, WDATA, RLOAD, RDATA, DONE.
REQ-020 IDLE -> CMD on the synchronized cs_n falling edge; the bit counter SHALL be cleared to 0.
REQ-021 In CMD, after ADDR_W+1 rising edges: if R/W=0, go to WDATA; if R/W=1, go to RLOAD and pulse rd_en for one clk with addr valid.
REQ-022 In RLOAD, one clk after rd_en, the block SHALL latch rdata into the shift register and go to RDATA.
REQ-023 In RDATA, the block SHALL assert sdio_oe and drive the data MSB on the first sclk falling edge after the command; it SHALL shift out one bit per falling edge.
REQ-024 After the DATA_W-th falling edge in RDATA, sdio_oe SHALL stay asserted until the next rising edge and SHALL deassert on that edge; the FSM SHALL then go to DONE.
REQ-025 In WDATA, after DATA_W rising edges, the block SHALL pulse wr_en for one clk with addr and wdata valid, then go to DONE.
REQ-026 DONE SHALL ignore further sclk edges and hold sdio_oe=0 until cs_n rises, then return to IDLE.
REQ-027 The synchronized cs_n rising edge in any state SHALL force IDLE within one clk, deassert sdio_oe, and clear counters; a partial write SHALL produce no wr_en.
REQ-028 sdio_oe SHALL never be 1 outside RDATA, so the SDIO line is never driven while the master drives it.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 addr and wdata SHALL hold their last values between strobes.

Reset
REQ-031 While rst_n=0: FSM=IDLE; sdio_oe=0, sdio_out=0, wr_en=0, rd_en=0, busy=0, addr=0, wdata=0; counters, shift registers and synchronizers are 0 (cs_n synchronizer reset to 1).
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately with no strobe; after release, the block SHALL wait for a fresh cs_n falling edge.

Verification
REQ-033 Write: cs_n low, send 0x12 then 0xA5 -> exactly one wr_en pulse with addr=0x12 and wdata=0xA5; sdio_oe stays 0 throughout.
REQ-034 Read: send 0x85 with rdata=0x3C returned one clk after rd_en -> rd_en pulses once with addr=0x05; master samples 0,0,1,1,1,1,0,0; sdio_oe is 1 only during those 8 bits.
REQ-035 Abort: cs_n rises after 4 data bits of a write -> no wr_en, busy=0 within 3 clk of the sclk/cs_n pin change; the next full frame behaves normally.
REQ-036 Extra clocks: 20 sclk pulses in one write frame -> a single wr_en; state stays DONE until cs_n rises.
REQ-037 Reset mid-read: rst_n low during RDATA bit 3 -> sdio_oe=0 immediately and all outputs at reset values.
REQ-038 Back-to-back: write 0x01/0x55 then read 0x81 with cs_n high for 4 clk between frames -> both frames complete correctly, rd_en addr=0x01.
